eth_phy_rst_seq: RTL and testbench
==================================

# eth_phy_rst_seq

Parametrised Ethernet PHY reset sequencer and management-clock generator for the FPGA Ethernet front end. It holds the PHY's active-low reset for a programmable number of enabled cycles and then waits a programmable settle time. It then flags the PHY ready and starts generating MDC for the SMI master. Unlike a fixed one-shot power-up delay, it accepts run-time soft-reset requests, honours a clock enable for time-base scaling, and counts reset events.

## Interface
- ASSERT_CYCLES, 20: enabled cycles `eth_rst` is held low per reset sequence (≥1).
- SETTLE_CYCLES, 50: enabled cycles after `eth_rst` release before `phy_ready` (≥1).
- MDC_DIV, 10: `sys_clk` cycles per MDC half-period (≥1); MDC period = 2·MDC_DIV.
- CNT_W, 16: width of the sequence counter; ASSERT_CYCLES and SETTLE_CYCLES must each be ≤ 2^CNT_W.
- sys_clk  input  1  system clock; the block's only clock.
- rst  input  1  synchronous reset, active-high.
- clk_en  input  1  time-base enable; sequence counter advances only when high.
- soft_rst_req  input  1  single-cycle request to re-run the PHY reset sequence.
- eth_rst  output  1  PHY reset, active-low (0 = PHY held in reset).
- phy_ready  output  1  high once the sequence has completed.
- eth_mdc  output  1  SMI management clock.
- busy  output  1  high in ASSERT or SETTLE.
- rst_count  output  8  number of accepted soft-reset requests, saturating at 255.

## Operation
- Uses a three-state FSM: ASSERT, SETTLE, READY. The sequence counter `cnt` is CNT_W bits wide.
- All outputs are registered.
- On `rst`:
  - state = ASSERT, cnt = 0;
  - `eth_rst`=0, `phy_ready`=0, `eth_mdc`=0, `busy`=1, `rst_count`=0;
  - MDC divider = 0.
- ASSERT:
  - `eth_rst`=0, `busy`=1.
  - On each `clk_en` cycle, cnt increments.
  - When `clk_en` is high and cnt == ASSERT_CYCLES-1: move to SETTLE, cnt ← 0, `eth_rst` ← 1.
- SETTLE:
  - `eth_rst`=1, `busy`=1.
  - On each `clk_en` cycle, cnt increments.
  - When `clk_en` is high and cnt == SETTLE_CYCLES-1: move to READY, `phy_ready` ← 1, `busy` ← 0.
- READY:
  - `eth_rst`=1, `phy_ready`=1.
  - The MDC divider counts every `sys_clk`, independent of `clk_en`. It toggles `eth_mdc` when the divider reaches MDC_DIV-1, then wraps to 0.
- `soft_rst_req` sampled high in any state:
  - next state = ASSERT, cnt ← 0;
  - `eth_rst` ← 0, `phy_ready` ← 0, `busy` ← 1;
  - `eth_mdc` ← 0, divider ← 0.
  - In ASSERT the request restarts the count, extending the reset.
  - In SETTLE the request aborts the settle phase.
- `rst_count` increments on every sampled `soft_rst_req` and holds at 255.
- Simultaneous events:
  - `soft_rst_req` has priority over a terminal count in the same cycle.
  - `rst` has priority over everything.
- `clk_en` low freezes cnt and the state in ASSERT and SETTLE. It does not affect the MDC or request handling.
- Leaving READY for any reason forces `eth_mdc` low on the next edge. No MDC glitch shorter than MDC_DIV cycles may appear except this truncation.

## Timing
- With `clk_en`=1 continuously, take edge 0 as the last edge with `rst` high:
  - `eth_rst` rises after edge ASSERT_CYCLES;
  - `phy_ready` rises after edge ASSERT_CYCLES+SETTLE_CYCLES, and `busy` falls on the same edge.
- After `phy_ready` rises, the first `eth_mdc` rising edge occurs MDC_DIV cycles later.
- `soft_rst_req` at edge N drives `eth_rst`=0 and `phy_ready`=0 after edge N (one-cycle latency).
- A complete re-sequence is then ASSERT_CYCLES+SETTLE_CYCLES enabled cycles.
- With `clk_en` asserted every k cycles, the ASSERT and SETTLE durations scale by k. The MDC period does not scale.

## Test plan
- Power-up, defaults, `clk_en`=1:
  - `eth_rst` low through 20 cycles after `rst` release, high at cycle 20;
  - `phy_ready`/`busy` change at cycle 70;
  - first `eth_mdc` rise at cycle 80, period 20.
- `clk_en` pulsed 1-in-4 → `eth_rst` rises at cycle 80 and `phy_ready` at cycle 280; MDC period stays 20.
- `soft_rst_req` pulse while READY:
  - next cycle `eth_rst`=0, `phy_ready`=0, `eth_mdc`=0, `rst_count`=1;
  - `phy_ready` returns 70 cycles later.
- `soft_rst_req` at ASSERT cnt=15 → `eth_rst` low for 16+20 cycles in total. `soft_rst_req` during SETTLE → back to ASSERT with `eth_rst` low the next cycle.
- `soft_rst_req` coincident with the SETTLE terminal count → `phy_ready` stays 0, state = ASSERT.
- 300 `soft_rst_req` pulses → `rst_count` saturates at 255. Then `rst` mid-SETTLE → all outputs at reset values the next cycle, `rst_count`=0.

Source files
------------

// File: rtl/eth_phy_rst_seq.sv
// Ethernet PHY reset sequencer with MDC generation.
// Holds the PHY in reset, waits for it to settle, then runs MDC.
module eth_phy_rst_seq #(
    parameter int ASSERT_CYCLES = 20,
    parameter int SETTLE_CYCLES = 50,
    parameter int MDC_DIV       = 10,
    parameter int CNT_W         = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       soft_rst_req,
    output logic       eth_rst,
    output logic       phy_ready,
    output logic       eth_mdc,
    output logic       busy,
    output logic [7:0] rst_count
);

    localparam int DIV_W = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] D_LAST = DIV_W'(MDC_DIV - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_SETTLE,
        S_READY
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             eth_rst_d;
    logic             ready_d;
    logic             mdc_d;
    logic             busy_d;
    logic [7:0]       rc_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_ASSERT;
            cnt_q     <= '0;
            div_q     <= '0;
            eth_rst   <= 1'b0;
            phy_ready <= 1'b0;
            eth_mdc   <= 1'b0;
            busy      <= 1'b1;
            rst_count <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            eth_rst   <= eth_rst_d;
            phy_ready <= ready_d;
            eth_mdc   <= mdc_d;
            busy      <= busy_d;
            rst_count <= rc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        eth_rst_d = eth_rst;
        ready_d   = phy_ready;
        mdc_d     = eth_mdc;
        busy_d    = busy;
        rc_d      = rst_count;

        if (soft_rst_req) begin
            // A request wins over any terminal count this cycle
            state_d   = S_ASSERT;
            cnt_d     = '0;
            div_d     = '0;
            eth_rst_d = 1'b0;
            ready_d   = 1'b0;
            mdc_d     = 1'b0;
            busy_d    = 1'b1;
            if (rst_count != 8'hff) begin
                rc_d = rst_count + 8'd1;
            end
        end else begin
            unique case (state_q)
                S_ASSERT: begin
                    eth_rst_d = 1'b0;
                    ready_d   = 1'b0;
                    mdc_d     = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = '0;
                    if (clk_en) begin
                        if (cnt_q == A_LAST) begin
                            state_d   = S_SETTLE;
                            cnt_d     = '0;
                            eth_rst_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    eth_rst_d = 1'b1;
                    ready_d   = 1'b0;
                    mdc_d     = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = '0;
                    if (clk_en) begin
                        if (cnt_q == S_LAST) begin
                            state_d = S_READY;
                            cnt_d   = '0;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_READY: begin
                    eth_rst_d = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    // MDC runs off sys_clk so its period ignores clk_en
                    if (div_q == D_LAST) begin
                        div_d = '0;
                        mdc_d = ~eth_mdc;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_phy_rst_seq.sv
// Randomised bench for eth_phy_rst_seq against a cycle-count model.
// Model tracks enabled cycles since sequence start and cycles in ready.
module tb_eth_phy_rst_seq;

    localparam int A = 20;
    localparam int S = 50;
    localparam int D = 10;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       eth_rst;
    logic       phy_ready;
    logic       eth_mdc;
    logic       busy;
    logic [7:0] rst_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int m_e = 0;
    int m_r = 0;
    int m_rc = 0;

    eth_phy_rst_seq #(
        .ASSERT_CYCLES(A),
        .SETTLE_CYCLES(S),
        .MDC_DIV(D),
        .CNT_W(16)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .clk_en(clk_en),
        .soft_rst_req(soft_rst_req),
        .eth_rst(eth_rst),
        .phy_ready(phy_ready),
        .eth_mdc(eth_mdc),
        .busy(busy),
        .rst_count(rst_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic q, input logic en);
        if (r) begin
            m_e = 0;
            m_r = 0;
            m_rc = 0;
        end else if (q) begin
            m_e = 0;
            m_r = 0;
            m_rc = (m_rc < 255) ? m_rc + 1 : 255;
        end else if (m_e >= A + S) begin
            m_r++;
        end else if (en) begin
            m_e++;
            m_r = 0;
        end
    endtask

    task automatic step(input logic r, input logic q, input logic en);
        logic e_rst;
        logic e_rdy;
        logic e_mdc;
        rst = r;
        soft_rst_req = q;
        clk_en = en;
        @(posedge sys_clk);
        #1;
        model_step(r, q, en);
        if (r) cyc = 0;
        else cyc++;
        e_rst = (m_e >= A);
        e_rdy = (m_e >= A + S);
        e_mdc = e_rdy && (((m_r / D) % 2) == 1);
        chk("eth_rst", 32'(eth_rst), 32'(e_rst));
        chk("phy_ready", 32'(phy_ready), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(!e_rdy));
        chk("eth_mdc", 32'(eth_mdc), 32'(e_mdc));
        chk("rst_count", 32'(rst_count), 32'(m_rc));
    endtask

    initial begin
        int t_rst;
        int t_rdy;
        int t_mdc;
        int t_mdc2;
        logic p_mdc;

        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_eth_rst", 32'(eth_rst), 32'd0);

        // Power-up with clk_en held high
        t_rst = -1; t_rdy = -1; t_mdc = -1; t_mdc2 = -1;
        p_mdc = 1'b0;
        for (int i = 0; i < 130; i++) begin
            step(0, 0, 1);
            if (t_rst < 0 && eth_rst) t_rst = cyc;
            if (t_rdy < 0 && phy_ready) t_rdy = cyc;
            if (eth_mdc && !p_mdc) begin
                if (t_mdc < 0) t_mdc = cyc;
                else if (t_mdc2 < 0) t_mdc2 = cyc;
            end
            p_mdc = eth_mdc;
        end
        chk("pu_eth_rst_rise", 32'(t_rst), 32'd20);
        chk("pu_ready_rise", 32'(t_rdy), 32'd70);
        chk("pu_mdc_rise", 32'(t_mdc), 32'd80);
        chk("pu_mdc_period", 32'(t_mdc2 - t_mdc), 32'd20);

        // clk_en 1-in-4
        step(1, 0, 0);
        t_rst = -1; t_rdy = -1; t_mdc = -1; t_mdc2 = -1;
        p_mdc = 1'b0;
        for (int i = 0; i < 340; i++) begin
            step(0, 0, ((cyc + 1) % 4) == 0);
            if (t_rst < 0 && eth_rst) t_rst = cyc;
            if (t_rdy < 0 && phy_ready) t_rdy = cyc;
            if (eth_mdc && !p_mdc) begin
                if (t_mdc < 0) t_mdc = cyc;
                else if (t_mdc2 < 0) t_mdc2 = cyc;
            end
            p_mdc = eth_mdc;
        end
        chk("div4_eth_rst_rise", 32'(t_rst), 32'd80);
        chk("div4_ready_rise", 32'(t_rdy), 32'd280);
        chk("div4_mdc_period", 32'(t_mdc2 - t_mdc), 32'd20);

        // Soft reset while ready
        step(0, 1, 1);
        chk("sr_eth_rst", 32'(eth_rst), 32'd0);
        chk("sr_mdc", 32'(eth_mdc), 32'd0);
        chk("sr_count", 32'(rst_count), 32'd1);
        t_rdy = -1;
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 1);
            if (t_rdy < 0 && phy_ready) t_rdy = i + 1;
        end
        chk("sr_ready_return", 32'(t_rdy), 32'd70);

        // Request at ASSERT cnt=15 extends the reset
        step(1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1);
        step(0, 1, 1);
        t_rst = -1;
        for (int i = 0; i < 60 && t_rst < 0; i++) begin
            step(0, 0, 1);
            if (eth_rst) t_rst = cyc;
        end
        chk("ext_low_cycles", 32'(t_rst), 32'd36);

        // Request in the middle of SETTLE
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        step(0, 1, 1);
        chk("settle_abort", 32'(eth_rst), 32'd0);

        // Request coincident with SETTLE terminal count
        step(1, 0, 0);
        for (int i = 0; i < 200 && m_e < A + S - 1; i++) step(0, 0, 1);
        chk("coinc_setup", 32'(m_e), 32'(A + S - 1));
        step(0, 1, 1);
        chk("coinc_ready", 32'(phy_ready), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 2999) == 0,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0);
        end

        // Saturation then reset mid-settle
        for (int i = 0; i < 300; i++) step(0, 1, 1'($urandom_range(0, 1)));
        chk("sat_count", 32'(rst_count), 32'd255);
        for (int i = 0; i < A + 10; i++) step(0, 0, 1);
        chk("mid_settle", 32'(eth_rst & busy), 32'd1);
        step(1, 0, 1);
        chk("rst_eth_rst", 32'(eth_rst), 32'd0);
        chk("rst_ready", 32'(phy_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mdc", 32'(eth_mdc), 32'd0);
        chk("rst_count0", 32'(rst_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
